// File: rtl/posit_add_arbiter.sv
// Two-requester round-robin front end sharing one combinational posit adder (Optimised_PA),
// with a 2-stage operand/result pipeline. Define POSIT_ARB_SUB_EN to add per-request subtract.

module optimised_pa #(
    parameter int N  = 32,
    parameter int ES = 2
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic [N-1:0] out
);
    localparam int MW  = N - ES;
    localparam int SW  = MW + 4;
    localparam int FBW = SW - 1;
    localparam int VW  = 2 + ES + FBW + N;
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    // Split a non-negative posit into its total scale (regime*2^ES + exponent) and 1.fraction.
    function automatic void decode(input logic [N-1:0] p_abs, output int scale,
                                   output logic [MW-1:0] mant);
        logic [N-2:0] body;
        logic [N-2:0] rest;
        int run;
        int k;
        logic done;
        body = p_abs[N-2:0];
        run  = 0;
        done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done && body[i] == body[N-2]) run++;
            else done = 1'b1;
        end
        rest  = body << (run + 1);
        k     = body[N-2] ? run - 1 : -run;
        scale = k * (1 << ES) + int'(rest[N-2 -: ES]);
        mant  = {1'b1, rest[N-2-ES:0]};
    endfunction

    logic [N-1:0]  a_abs;
    logic [N-1:0]  b_abs;
    logic [N-1:0]  big_abs;
    logic [N-1:0]  sml_abs;
    logic          swap;
    logic          big_sign;
    logic          sml_sign;
    int            sc_big;
    int            sc_sml;
    int            shamt;
    int            pos;
    int            res_scale;
    int            k;
    int            e;
    logic [MW-1:0] m_big;
    logic [MW-1:0] m_sml;
    logic [SW-1:0] big_e;
    logic [SW-1:0] sml_e;
    logic [SW-1:0] sml_sh;
    logic [SW-1:0] sum;
    logic [SW-1:0] norm;
    logic [VW-1:0] v;
    logic [N-2:0]  top;
    logic          align_sticky;
    logic          guard;
    logic          round_sticky;

    always_comb begin
        a_abs    = in1[N-1] ? (~in1 + 1'b1) : in1;
        b_abs    = in2[N-1] ? (~in2 + 1'b1) : in2;
        swap     = b_abs > a_abs;
        big_abs  = swap ? b_abs : a_abs;
        sml_abs  = swap ? a_abs : b_abs;
        big_sign = swap ? in2[N-1] : in1[N-1];
        sml_sign = swap ? in1[N-1] : in2[N-1];
        decode(big_abs, sc_big, m_big);
        decode(sml_abs, sc_sml, m_sml);

        // Three guard bits below the mantissa plus a carry bit above it; lost bits fold into a sticky LSB.
        shamt = sc_big - sc_sml;
        big_e = {1'b0, m_big, 3'b000};
        sml_e = {1'b0, m_sml, 3'b000};
        if (shamt >= SW) begin
            sml_sh       = '0;
            align_sticky = |sml_e;
        end else begin
            sml_sh       = sml_e >> shamt;
            align_sticky = (sml_sh << shamt) != sml_e;
        end
        sml_sh[0] = sml_sh[0] | align_sticky;
        sum = (big_sign == sml_sign) ? big_e + sml_sh : big_e - sml_sh;

        pos = 0;
        for (int i = 0; i < SW; i++) begin
            if (sum[i]) pos = i;
        end
        res_scale = sc_big + pos - (SW - 2);
        norm      = sum << (SW - 1 - pos);
        k         = res_scale >>> ES;
        e         = res_scale - k * (1 << ES);

        v            = '0;
        guard        = 1'b0;
        round_sticky = 1'b0;
        if (k > N - 2) begin
            top = '1;
        end else if (k < -(N - 2)) begin
            top = {{(N-2){1'b0}}, 1'b1};
        end else begin
            // Regime seed shifted right builds the run-length code; everything below lands in round bits.
            v = {((k >= 0) ? 2'b10 : 2'b01), ES'(e), norm[FBW-1:0], {N{1'b0}}};
            if (k >= 0) v = $signed(v) >>> k;
            else        v = v >> (-k - 1);
            top          = v[VW-1 -: N-1];
            guard        = v[VW-N];
            round_sticky = |v[VW-N-1:0];
            if (guard && (round_sticky || top[0]) && (top != '1)) top = top + 1'b1;
        end

        if (in1 == NAR || in2 == NAR) out = NAR;
        else if (in1 == '0)           out = in2;
        else if (in2 == '0)           out = in1;
        else if (sum == '0)           out = '0;
        else                          out = big_sign ? (~{1'b0, top} + 1'b1) : {1'b0, top};
    end
endmodule

module posit_add_arbiter #(
    parameter int N  = 32,
    parameter int ES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
`ifdef POSIT_ARB_SUB_EN
    input  logic         req0_sub,
`endif
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
`ifdef POSIT_ARB_SUB_EN
    input  logic         req1_sub,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_id,
    output logic         busy
);
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic         op_id_q, op_id_d;
    logic         op_valid_q, op_valid_d;
    logic         op_sub_q, op_sub_d;
    logic [N-1:0] res_data_q, res_data_d;
    logic         res_id_q, res_id_d;
    logic         res_valid_q, res_valid_d;
    logic         rr_ptr_q, rr_ptr_d;

    logic         out_free;
    logic         s1_free;
    logic         grant0;
    logic         grant1;
    logic         accept0;
    logic         accept1;
    logic         advance;
    logic [N-1:0] add_in2;
    logic [N-1:0] add_out;

    // Subtraction is addition of the posit negation, which is the two's complement of the word.
    assign add_in2 = op_sub_q ? (~op_b_q + 1'b1) : op_b_q;

    optimised_pa #(.N(N), .ES(ES)) u_adder (
        .in1 (op_a_q),
        .in2 (add_in2),
        .out (add_out)
    );

    always_comb begin
        out_free = !res_valid_q | res_ready;
        s1_free  = !op_valid_q | out_free;
        grant0   = req0_valid & (!req1_valid | rr_ptr_q);
        grant1   = req1_valid & (!req0_valid | !rr_ptr_q);
        accept0  = grant0 & s1_free;
        accept1  = grant1 & s1_free;
        advance  = op_valid_q & out_free;

        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        op_valid_d  = op_valid_q;
        op_sub_d    = op_sub_q;
        rr_ptr_d    = rr_ptr_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;

        if (accept0 || accept1) begin
            op_a_d     = accept1 ? req1_a : req0_a;
            op_b_d     = accept1 ? req1_b : req0_b;
            op_id_d    = accept1;
            op_valid_d = 1'b1;
            rr_ptr_d   = accept1;
`ifdef POSIT_ARB_SUB_EN
            op_sub_d   = accept1 ? req1_sub : req0_sub;
`else
            op_sub_d   = 1'b0;
`endif
        end else if (advance) begin
            op_valid_d = 1'b0;
        end

        if (advance) begin
            res_data_d  = add_out;
            res_id_d    = op_id_q;
            res_valid_d = 1'b1;
        end else if (res_ready && res_valid_q) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            op_valid_q  <= 1'b0;
            op_sub_q    <= 1'b0;
            rr_ptr_q    <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            op_valid_q  <= op_valid_d;
            op_sub_q    <= op_sub_d;
            rr_ptr_q    <= rr_ptr_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign req0_ready = rst_n & accept0;
    assign req1_ready = rst_n & accept1;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_id     = res_id_q;
    assign busy       = op_valid_q | res_valid_q;
endmodule

// File: tb/tb_posit_add_arbiter.sv
// Directed-vector bench for posit_add_arbiter: reset, arithmetic, round-robin, backpressure, mid-flight reset.
// Define POSIT_ARB_SUB_EN to also exercise the subtract path.

module tb_posit_add_arbiter;
    localparam int N = 32;
    localparam logic [31:0] P_ZERO    = 32'h00000000;
    localparam logic [31:0] P_ONE     = 32'h40000000;
    localparam logic [31:0] P_TWO     = 32'h48000000;
    localparam logic [31:0] P_THREE   = 32'h4C000000;
    localparam logic [31:0] P_FOUR    = 32'h50000000;
    localparam logic [31:0] P_HALF    = 32'h38000000;
    localparam logic [31:0] P_ONEHALF = 32'h44000000;
    localparam logic [31:0] P_MONE    = 32'hC0000000;
    localparam logic [31:0] P_NAR     = 32'h80000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [N-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [N-1:0] req1_a, req1_b;
    logic         res_valid, res_ready;
    logic [N-1:0] res_data;
    logic         res_id;
    logic         busy;
`ifdef POSIT_ARB_SUB_EN
    logic         req0_sub, req1_sub;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    posit_add_arbiter #(.N(N), .ES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
`ifdef POSIT_ARB_SUB_EN
        .req0_sub   (req0_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef POSIT_ARB_SUB_EN
        .req1_sub   (req1_sub),
`endif
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    task automatic drive_idle();
        req0_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
`ifdef POSIT_ARB_SUB_EN
        req0_sub   = 1'b0;
        req1_sub   = 1'b0;
`endif
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks += 6;
        if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req0_ready got %b want 0", req0_ready); end
        if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1_ready got %b want 0", req1_ready); end
        if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid got %b want 0", res_valid); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (res_data !== P_ZERO) begin errors++; $display("[TB] FAIL reset_res_data got %h want %h", res_data, P_ZERO); end
        if (res_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_id got %b want 0", res_id); end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        res_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_a     = P_ONE;
        req0_b     = P_ONE;
        #1;
        checks += 2;
        if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_req0_ready got %b want 1", req0_ready); end
        if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_req1_ready got %b want 0", req1_ready); end
        @(negedge clk);
        drive_idle();
        #1;
        checks += 2;
        if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid got %b want 0", res_valid); end
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %b want 1", busy); end
        @(negedge clk);
        #1;
        checks += 3;
        if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_res_valid got %b want 1", res_valid); end
        if (res_data !== P_TWO) begin errors++; $display("[TB] FAIL single_res_data got %h want %h", res_data, P_TWO); end
        if (res_id !== 1'b0) begin errors++; $display("[TB] FAIL single_res_id got %b want 0", res_id); end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_drained_busy got %b want 0", busy); end
    endtask

    task automatic test_tie_arbitration();
        logic exp_id;
        pulse_reset();
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) begin
                req0_valid = 1'b1; req0_a = P_ONE; req0_b = P_ONE;
                req1_valid = 1'b1; req1_a = P_TWO; req1_b = P_TWO;
            end else begin
                drive_idle();
            end
            #1;
            if (i < 4) begin
                exp_id = (i % 2 == 0);
                checks += 2;
                if (req1_ready !== exp_id) begin errors++; $display("[TB] FAIL tie_req1_ready[%0d] got %b want %b", i, req1_ready, exp_id); end
                if (req0_ready !== !exp_id) begin errors++; $display("[TB] FAIL tie_req0_ready[%0d] got %b want %b", i, req0_ready, !exp_id); end
            end
            if (i >= 2) begin
                exp_id = ((i - 2) % 2 == 0);
                checks += 3;
                if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL tie_res_valid[%0d] got %b want 1", i, res_valid); end
                if (res_id !== exp_id) begin errors++; $display("[TB] FAIL tie_res_id[%0d] got %b want %b", i, res_id, exp_id); end
                if (res_data !== (exp_id ? P_FOUR : P_TWO)) begin
                    errors++;
                    $display("[TB] FAIL tie_res_data[%0d] got %h want %h", i, res_data, exp_id ? P_FOUR : P_TWO);
                end
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] va [5] = '{P_ONE, P_NAR, P_HALF, P_ONE, P_ONE};
        logic [31:0] vb [5] = '{P_MONE, P_ONE, P_ONE, P_TWO, P_ZERO};
        logic [31:0] vs [5] = '{P_ZERO, P_NAR, P_ONEHALF, P_THREE, P_ONE};
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 5) begin
                req1_valid = 1'b1;
                req1_a     = va[i];
                req1_b     = vb[i];
            end else begin
                drive_idle();
            end
            #1;
            if (i < 5) begin
                checks++;
                if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL arith_req1_ready[%0d] got %b want 1", i, req1_ready); end
            end
            if (i >= 2) begin
                checks += 3;
                if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL arith_res_valid[%0d] got %b want 1", i - 2, res_valid); end
                if (res_data !== vs[i-2]) begin errors++; $display("[TB] FAIL arith_res_data[%0d] got %h want %h", i - 2, res_data, vs[i-2]); end
                if (res_id !== 1'b1) begin errors++; $display("[TB] FAIL arith_res_id[%0d] got %b want 1", i - 2, res_id); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vb  [4] = '{P_ONE, P_TWO, P_HALF, P_ZERO};
        logic [31:0] exp [4] = '{P_TWO, P_THREE, P_ONEHALF, P_ONE};
        logic [31:0] got [$];
        logic [31:0] val;
        int p = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            res_ready = (c >= 5);
            if (p < 4) begin
                req0_valid = 1'b1;
                req0_a     = P_ONE;
                req0_b     = vb[p];
            end else begin
                drive_idle();
            end
            #1;
            if (res_valid && res_ready) got.push_back(res_data);
            if (c >= 2 && c < 5) begin
                checks += 3;
                if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid[%0d] got %b want 1", c, res_valid); end
                if (res_data !== P_TWO) begin errors++; $display("[TB] FAIL bp_hold_data[%0d] got %h want %h", c, res_data, P_TWO); end
                if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low[%0d] got %b want 0", c, req0_ready); end
            end
            if (c == 5) begin
                checks++;
                if (p !== 2) begin errors++; $display("[TB] FAIL bp_accept_count got %0d want 2", p); end
            end
            if (req0_valid && req0_ready) p++;
        end
        checks++;
        if (got.size() !== 4) begin errors++; $display("[TB] FAIL bp_result_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            val = (i < got.size()) ? got[i] : 'x;
            checks++;
            if (val !== exp[i]) begin errors++; $display("[TB] FAIL bp_order[%0d] got %h want %h", i, val, exp[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        res_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = P_ONE; req0_b = P_ONE;
        @(negedge clk);
        req0_a = P_TWO; req0_b = P_TWO;
        @(negedge clk);
        #1;
        checks += 2;
        if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_full_valid got %b want 1", res_valid); end
        if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_full_ready got %b want 0", req0_ready); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid got %b want 0", res_valid); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy got %b want 0", busy); end
        if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready got %b want 0", req0_ready); end
        @(negedge clk);
        drive_idle();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        req1_valid = 1'b1; req1_a = P_HALF; req1_b = P_ONE;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_post_ready got %b want 1", req1_ready); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_stale got %b want 0", res_valid); end
        @(negedge clk);
        #1;
        checks += 3;
        if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_post_valid got %b want 1", res_valid); end
        if (res_data !== P_ONEHALF) begin errors++; $display("[TB] FAIL mid_post_data got %h want %h", res_data, P_ONEHALF); end
        if (res_id !== 1'b1) begin errors++; $display("[TB] FAIL mid_post_id got %b want 1", res_id); end
        @(negedge clk);
    endtask

`ifdef POSIT_ARB_SUB_EN
    task automatic test_sub();
        res_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = P_TWO; req0_b = P_ONE; req0_sub = 1'b1;
        @(negedge clk);
        req0_a = P_ONE; req0_b = P_ONE; req0_sub = 1'b1;
        @(negedge clk);
        drive_idle();
        #1;
        checks += 2;
        if (res_data !== P_ONE) begin errors++; $display("[TB] FAIL sub_two_minus_one got %h want %h", res_data, P_ONE); end
        if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL sub_valid got %b want 1", res_valid); end
        @(negedge clk);
        #1;
        checks++;
        if (res_data !== P_ZERO) begin errors++; $display("[TB] FAIL sub_one_minus_one got %h want %h", res_data, P_ZERO); end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        res_ready = 1'b1;
        drive_idle();
        test_reset();
        test_single_add();
        test_tie_arbitration();
        test_arith();
        test_backpressure();
        test_reset_midflight();
`ifdef POSIT_ARB_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
